// File: rtl/axis_packet_segmenter_if.sv
// AXI-Stream bundle shared by the segmenter input and output sides.
interface axis_packet_segmenter_if #(
    parameter int BYTE_WIDTH = 8,
    parameter int USER_WIDTH = 8
) ();
    // A zero-width user path still needs a physical 1-bit signal.
    localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;

    logic [BYTE_WIDTH*8-1:0] tdata;
    logic [BYTE_WIDTH-1:0]   tkeep;
    logic [UW-1:0]           tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_packet_segmenter.sv
// AXI-Stream segmenter: forces TLAST every MAX_BEATS beats, passes natural
// TLAST through, and drives the output from a 2-entry skid buffer.
//
//  state | meaning
//  EMPTY | no beat held, output invalid, input ready
//  ONE   | output register holds a beat, input ready
//  TWO   | output and skid registers both full, input stalled
module axis_packet_segmenter #(
    parameter int BYTE_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [CNT_WIDTH-1:0] MAX_BEATS,
    axis_packet_segmenter_if.slave  s_axis,
    axis_packet_segmenter_if.master m_axis,
    output logic [31:0]          SEG_COUNT,
    output logic [31:0]          PKT_COUNT
);
    localparam int DW = BYTE_WIDTH * 8;
    localparam int UW = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    buf_state_t state, state_nxt;

    logic                 in_acc, out_acc;
    logic                 load_out_in, load_out_skid, load_skid;

    logic [CNT_WIDTH-1:0] cnt, lim, lim_eff;
    logic                 seg_force, beat_last;
    logic [UW-1:0]        user_in;

    logic [DW-1:0]         out_data, skid_data;
    logic [BYTE_WIDTH-1:0] out_keep, skid_keep;
    logic [UW-1:0]         out_user, skid_user;
    logic                  out_last, skid_last;

    // Handshake flags come straight from the state register; RESET gating keeps
    // both low while reset is held and lets ready rise as soon as it drops.
    assign s_axis.tready = (state != TWO) & ~RESET;
    assign m_axis.tvalid = (state != EMPTY) & ~RESET;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;

    assign in_acc  = s_axis.tvalid & s_axis.tready;
    assign out_acc = m_axis.tvalid & m_axis.tready;
    assign user_in = (USER_WIDTH > 0) ? s_axis.tuser : '0;

    // Segment limit is sampled on the first beat of a segment, so the live
    // MAX_BEATS value applies when cnt is zero and the latched copy otherwise.
    always_comb begin
        lim_eff   = (cnt == '0) ? MAX_BEATS : lim;
        seg_force = (lim_eff != '0) && (cnt == (lim_eff - CNT_ONE));
        beat_last = s_axis.tlast | seg_force;
    end

    // Beat counter, latched limit and event counters advance on input accept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= '0;
            lim       <= '0;
            SEG_COUNT <= '0;
            PKT_COUNT <= '0;
        end else if (in_acc) begin
            if (cnt == '0)
                lim <= MAX_BEATS;
            if (beat_last)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;
            if (seg_force && !s_axis.tlast)
                SEG_COUNT <= SEG_COUNT + 32'd1;
            if (s_axis.tlast)
                PKT_COUNT <= PKT_COUNT + 32'd1;
        end
    end

    // Buffer state register.
    always_ff @(posedge CLK) begin
        if (RESET)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Buffer next-state and register load selects.
    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_acc) begin
                    state_nxt   = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (in_acc && !out_acc) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (in_acc && out_acc) begin
                    load_out_in = 1'b1;
                end else if (out_acc) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_acc) begin
                    state_nxt     = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Payload registers; contents are don't-care while the buffer is empty.
    always_ff @(posedge CLK) begin
        if (load_out_in) begin
            out_data <= s_axis.tdata;
            out_keep <= s_axis.tkeep;
            out_user <= user_in;
            out_last <= beat_last;
        end else if (load_out_skid) begin
            out_data <= skid_data;
            out_keep <= skid_keep;
            out_user <= skid_user;
            out_last <= skid_last;
        end
        if (load_skid) begin
            skid_data <= s_axis.tdata;
            skid_keep <= s_axis.tkeep;
            skid_user <= user_in;
            skid_last <= beat_last;
        end
    end
endmodule

// File: tb/tb_axis_packet_segmenter.sv
// Bench for axis_packet_segmenter: directed packets, a queue/occupancy model
// checked every cycle, and literal TLAST positions and counter values.
module tb_axis_packet_segmenter;
    logic        CLK;
    logic        RESET;
    logic [15:0] MAX_BEATS;
    logic [31:0] SEG_COUNT, PKT_COUNT;

    axis_packet_segmenter_if #(.BYTE_WIDTH(8), .USER_WIDTH(8)) s_if ();
    axis_packet_segmenter_if #(.BYTE_WIDTH(8), .USER_WIDTH(8)) m_if ();

    axis_packet_segmenter #(.BYTE_WIDTH(8), .USER_WIDTH(8), .CNT_WIDTH(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MAX_BEATS (MAX_BEATS),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .SEG_COUNT (SEG_COUNT),
        .PKT_COUNT (PKT_COUNT)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    int    vectors = 0;
    int    errors  = 0;
    beat_t exp_q[$];
    int    last_pos[$];
    int    out_total = 0;
    int    occ = 0;
    logic  drv_last = 0;
    logic  rmode = 0;
    logic  mrdy = 1;

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output ready: fixed or 50% random, changed just after each rising edge.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            m_if.tready = rmode ? 1'($urandom_range(0, 1)) : mrdy;
        end
    end

    // Model: occupancy counter plus FIFO of accepted beats with their expected TLAST.
    initial begin
        logic        stall_prev = 0;
        logic [63:0] pd = '0;
        logic [7:0]  pk = '0, pu = '0;
        logic        pl = 0;
        logic        in_acc, out_acc;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
                check("rst_tready", 64'(s_if.tready), 64'd0);
                exp_q.delete();
                occ = 0;
                stall_prev = 0;
            end else begin
                check("tvalid", 64'(m_if.tvalid), 64'(occ != 0));
                check("tready", 64'(s_if.tready), 64'(occ < 2));
                if (occ != 0 && exp_q.size() > 0) begin
                    check("tdata", m_if.tdata, exp_q[0].d);
                    check("tkeep", 64'(m_if.tkeep), 64'(exp_q[0].k));
                    check("tuser", 64'(m_if.tuser), 64'(exp_q[0].u));
                    check("tlast", 64'(m_if.tlast), 64'(exp_q[0].l));
                end
                if (stall_prev) begin
                    check("hold_tvalid", 64'(m_if.tvalid), 64'd1);
                    check("hold_tdata", m_if.tdata, pd);
                    check("hold_tkeep", 64'(m_if.tkeep), 64'(pk));
                    check("hold_tuser", 64'(m_if.tuser), 64'(pu));
                    check("hold_tlast", 64'(m_if.tlast), 64'(pl));
                end
                out_acc = (occ != 0) && m_if.tready;
                in_acc  = s_if.tvalid && (occ < 2);
                if (out_acc) begin
                    out_total++;
                    if (m_if.tlast) last_pos.push_back(out_total);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    occ--;
                end
                if (in_acc) begin
                    exp_q.push_back('{d: s_if.tdata, k: s_if.tkeep, u: s_if.tuser, l: drv_last});
                    occ++;
                end
                stall_prev = m_if.tvalid && !m_if.tready;
                pd = m_if.tdata;
                pk = m_if.tkeep;
                pu = m_if.tuser;
                pl = m_if.tlast;
            end
        end
    end

    // Offer beats 1..upto of a len-beat packet; expected TLAST from packet arithmetic.
    task automatic send(input int len, input int lim, input int upto);
        for (int i = 1; i <= upto; i++) begin
            logic acc;
            s_if.tdata  = {$urandom(), $urandom()};
            s_if.tkeep  = 8'($urandom());
            s_if.tuser  = 8'($urandom());
            s_if.tlast  = (i == len);
            drv_last    = (i == len) || (lim != 0 && (i % lim) == 0);
            s_if.tvalid = 1'b1;
            acc = 0;
            for (int c = 0; c < 1000 && !acc; c++) begin
                @(negedge CLK);
                acc = s_if.tready;
                @(posedge CLK);
                #1;
            end
            check("accept", 64'(acc), 64'd1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int c;
        for (c = 0; c < 2000 && occ != 0; c++) begin
            @(posedge CLK);
            #1;
        end
        check("drain", 64'(occ), 64'd0);
    endtask

    initial begin
        int base, nl;
        RESET       = 1'b1;
        MAX_BEATS   = 16'd0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_seg", 64'(SEG_COUNT), 64'd0);
        check("rst_pkt", 64'(PKT_COUNT), 64'd0);
        RESET = 1'b0;
        #1;
        check("tready_after_rst", 64'(s_if.tready), 64'd1);

        // T1: 10 beats, limit 4 -> TLAST on 4, 8, 10
        MAX_BEATS = 16'd4;
        base = out_total; nl = last_pos.size();
        send(10, 4, 10); drain();
        check("t1_nlast", 64'(last_pos.size() - nl), 64'd3);
        if (last_pos.size() >= nl + 3) begin
            check("t1_last0", 64'(last_pos[nl] - base), 64'd4);
            check("t1_last1", 64'(last_pos[nl+1] - base), 64'd8);
            check("t1_last2", 64'(last_pos[nl+2] - base), 64'd10);
        end
        check("t1_seg", 64'(SEG_COUNT), 64'd2);
        check("t1_pkt", 64'(PKT_COUNT), 64'd1);

        // T2: 4 beats, limit 4 -> single TLAST, no forced segment
        base = out_total; nl = last_pos.size();
        send(4, 4, 4); drain();
        check("t2_nlast", 64'(last_pos.size() - nl), 64'd1);
        if (last_pos.size() > nl) check("t2_last0", 64'(last_pos[nl] - base), 64'd4);
        check("t2_seg", 64'(SEG_COUNT), 64'd2);
        check("t2_pkt", 64'(PKT_COUNT), 64'd2);

        // T3: segmentation disabled, 300 beats
        MAX_BEATS = 16'd0;
        base = out_total; nl = last_pos.size();
        send(300, 0, 300); drain();
        check("t3_nlast", 64'(last_pos.size() - nl), 64'd1);
        if (last_pos.size() > nl) check("t3_last0", 64'(last_pos[nl] - base), 64'd300);
        check("t3_seg", 64'(SEG_COUNT), 64'd2);
        check("t3_pkt", 64'(PKT_COUNT), 64'd3);

        // T4: random output ready, limit 3, 100 beats -> 33 forced + 1 natural
        MAX_BEATS = 16'd3;
        rmode = 1;
        nl = last_pos.size();
        send(100, 3, 100); drain();
        rmode = 0;
        check("t4_nlast", 64'(last_pos.size() - nl), 64'd34);
        check("t4_seg", 64'(SEG_COUNT), 64'd35);
        check("t4_pkt", 64'(PKT_COUNT), 64'd4);

        // T5: limit 1 -> every beat carries TLAST
        MAX_BEATS = 16'd1;
        base = out_total; nl = last_pos.size();
        send(5, 1, 5); drain();
        check("t5_nlast", 64'(last_pos.size() - nl), 64'd5);
        if (last_pos.size() >= nl + 5)
            for (int j = 0; j < 5; j++) check("t5_lastpos", 64'(last_pos[nl+j] - base), 64'(j + 1));
        check("t5_seg", 64'(SEG_COUNT), 64'd39);
        check("t5_pkt", 64'(PKT_COUNT), 64'd5);

        // T6: reset mid-packet with the output stalled
        MAX_BEATS = 16'd4;
        mrdy = 0;
        repeat (2) @(posedge CLK);
        #1;
        send(6, 4, 2);
        check("t6_full_tready", 64'(s_if.tready), 64'd0);
        check("t6_full_tvalid", 64'(m_if.tvalid), 64'd1);
        RESET = 1'b1;
        #1;
        check("t6_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("t6_rst_seg", 64'(SEG_COUNT), 64'd0);
        check("t6_rst_pkt", 64'(PKT_COUNT), 64'd0);
        RESET = 1'b0;
        mrdy  = 1;
        #1;
        check("t6_tready_after_rst", 64'(s_if.tready), 64'd1);
        @(posedge CLK);
        #1;
        base = out_total; nl = last_pos.size();
        send(6, 4, 6); drain();
        check("t6_nlast", 64'(last_pos.size() - nl), 64'd2);
        if (last_pos.size() >= nl + 2) begin
            check("t6_last0", 64'(last_pos[nl] - base), 64'd4);
            check("t6_last1", 64'(last_pos[nl+1] - base), 64'd6);
        end
        check("t6_seg", 64'(SEG_COUNT), 64'd1);
        check("t6_pkt", 64'(PKT_COUNT), 64'd1);

        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
